// File: rtl/ct_spsram_fifo_pkg.sv
// Shared constants for the single-port-SRAM FIFO controller: default sizes,
// macro access kinds and the active-low control triple each one drives.
package ct_spsram_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 144;
  localparam int COUNT_WIDTH    = ADDR_WIDTH_DEF + 2;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_e;

  // Control triple packed as {CEN, GWEN, WEN fill value}, all active-low.
  localparam logic [2:0] CTRL_IDLE = 3'b111;
  localparam logic [2:0] CTRL_RD   = 3'b011;
  localparam logic [2:0] CTRL_WR   = 3'b000;

  function automatic logic [2:0] acc_ctrl(input acc_e acc);
    acc_ctrl = CTRL_IDLE;
    case (acc)
      ACC_RD:  acc_ctrl = CTRL_RD;
      ACC_WR:  acc_ctrl = CTRL_WR;
      default: acc_ctrl = CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ct_spsram_fifo_obuf.sv
// Two-entry output buffer holding data returned by the macro. Push and pop
// in the same cycle are both honoured; the head is presented combinationally.
module ct_spsram_fifo_obuf
  import ct_spsram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            ob_cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            cnt;

  // Storage entries: each slot loads only when the write index points at it.
  // Contents survive flush; the head is don't-care while the buffer is empty.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[gi] <= '0;
        end else if (push && !flush && (wr_idx == 1'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Index and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_idx <= ~wr_idx;
      if (pop)  rd_idx <= ~rd_idx;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign ob_cnt = cnt;
  assign head   = mem[rd_idx];

endmodule

// File: rtl/ct_spsram_fifo_ctrl.sv
// FIFO controller in front of a single-port SRAM macro. One macro access per
// cycle; reads win over writes whenever the output buffer has credit, and
// read data lands in a 2-entry buffer one cycle after the access.
module ct_spsram_fifo_ctrl
  import ct_spsram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  flush,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_rdy,
  output logic [ADDR_WIDTH+1:0] count,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic                  sram_CEN,
  output logic                  sram_GWEN,
  output logic [DATA_WIDTH-1:0] sram_WEN,
  output logic [DATA_WIDTH-1:0] sram_D,
  input  logic [DATA_WIDTH-1:0] sram_Q
);

  localparam int                  CW       = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] a_hold;
  logic [DATA_WIDTH-1:0] d_hold;
  logic [ADDR_WIDTH:0]   sram_cnt;
  logic                  inflight;
  logic [1:0]            ob_cnt;
  logic [CW-1:0]         count_reg;
  logic                  pop;
  logic                  credit_ok;
  logic                  rd_sel;
  logic                  wr_fire;
  acc_e                  acc;
  logic [2:0]            ctrl;

  // A pop frees one buffer slot this cycle, so it counts as credit for a read.
  assign pop       = rd_vld & rd_rdy & ~flush;
  assign credit_ok = ({1'b0, ob_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  // Both access requests are gated by the raw reset so the macro sees CEN
  // high the instant reset asserts, not at the next clock edge.
  assign rd_sel  = cpurst_b & ~flush & (sram_cnt != '0) & credit_ok;
  assign wr_rdy  = ~rd_sel & (sram_cnt < FULL_CNT) & ~flush;
  assign wr_fire = cpurst_b & wr_vld & wr_rdy;

  // Pick this cycle's macro access, read first.
  always_comb begin
    acc = ACC_IDLE;
    if (rd_sel) begin
      acc = ACC_RD;
    end else if (wr_fire) begin
      acc = ACC_WR;
    end
  end

  assign ctrl      = acc_ctrl(acc);
  assign sram_CEN  = ctrl[2];
  assign sram_GWEN = ctrl[1];
  assign sram_WEN  = {DATA_WIDTH{ctrl[0]}};
  // Address and write data hold their last driven value while idle.
  assign sram_A    = rd_sel ? rptr : (wr_fire ? wptr : a_hold);
  assign sram_D    = wr_fire ? wr_data : d_hold;

  // Pointer, occupancy and read-pipeline state. Pointers are exactly
  // ADDR_WIDTH bits wide, so DEPTH-1 -> 0 wraps naturally.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wptr      <= '0;
      rptr      <= '0;
      a_hold    <= '0;
      d_hold    <= '0;
      sram_cnt  <= '0;
      inflight  <= 1'b0;
      count_reg <= '0;
    end else begin
      a_hold <= sram_A;
      d_hold <= sram_D;
      if (flush) begin
        wptr      <= '0;
        rptr      <= '0;
        sram_cnt  <= '0;
        inflight  <= 1'b0;
        count_reg <= '0;
      end else begin
        if (wr_fire) wptr <= wptr + ADDR_WIDTH'(1);
        if (rd_sel)  rptr <= rptr + ADDR_WIDTH'(1);
        inflight <= rd_sel;
        case ({wr_fire, rd_sel})
          2'b10:   sram_cnt <= sram_cnt + (ADDR_WIDTH + 1)'(1);
          2'b01:   sram_cnt <= sram_cnt - (ADDR_WIDTH + 1)'(1);
          default: sram_cnt <= sram_cnt;
        endcase
        // Entries only enter via push and leave via pop; internal moves
        // between SRAM, in-flight read and buffer keep the total unchanged.
        case ({wr_fire, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  assign count  = count_reg;
  assign rd_vld = (ob_cnt != 2'd0);

  ct_spsram_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk       (forever_cpuclk),
    .rst_n     (cpurst_b),
    .flush     (flush),
    .push      (inflight & ~flush),
    .push_data (sram_Q),
    .pop       (pop),
    .ob_cnt    (ob_cnt),
    .head      (rd_data)
  );

endmodule
